// File: rtl/sdp_ram_param.sv
// Simple dual-port RAM: one write port, one read port, one clock. Byte-enable writes,
// read latency 0/1/2, selectable read-during-write result, optional zero-fill after reset.
module sdp_ram_param #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 1024,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int READ_LATENCY   = 1,
    parameter bit RDW_NEW        = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wre,
    input  logic [ADDR_W-1:0]   wad,
    input  logic [DATA_W-1:0]   di,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic                rre,
    input  logic [ADDR_W-1:0]   rad,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid,
    output logic                init_done
);
    localparam int              NB        = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_en;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_merged;

    // DEPTH need not be a power of two, so both addresses are range-checked.
    assign wr_in_range = {1'b0, wad} < DEPTH_X;
    assign rd_in_range = {1'b0, rad} < DEPTH_X;
    assign wr_en       = init_done & wre & wr_in_range;

    generate
        if (CLEAR_ON_RESET) begin : g_clear
            typedef enum logic {CLEAR, READY} state_t;

            state_t            state;
            state_t            state_nxt;
            logic [ADDR_W-1:0] cnt;
            logic [ADDR_W-1:0] cnt_nxt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state <= CLEAR;
                    cnt   <= '0;
                end else begin
                    state <= state_nxt;
                    cnt   <= cnt_nxt;
                end
            end

            // rst_n gates the clear write so reset alone never alters contents.
            always_comb begin
                state_nxt = state;
                cnt_nxt   = cnt;
                clr_en    = 1'b0;
                case (state)
                    CLEAR: begin
                        clr_en = rst_n;
                        if (cnt == LAST_ADDR) begin
                            state_nxt = READY;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + ADDR_W'(1);
                        end
                    end
                    READY: begin
                    end
                    default: begin
                        state_nxt = CLEAR;
                        cnt_nxt   = '0;
                    end
                endcase
            end

            assign init_done = (state == READY);
            assign clr_addr  = cnt;
        end else begin : g_no_clear
            assign init_done = 1'b1;
            assign clr_en    = 1'b0;
            assign clr_addr  = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem[wad][8*i +: 8] <= di[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = rd_in_range ? mem[rad] : '0;

    // Same-address write this cycle: optionally forward the enabled bytes of di.
    always_comb begin
        rd_merged = rd_word;
        if (RDW_NEW && wr_en && (wad == rad)) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    rd_merged[8*i +: 8] = di[8*i +: 8];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_lat0
            assign dout       = rd_word;
            assign dout_valid = init_done;
        end else begin : g_lat_reg
            logic [DATA_W-1:0] s1_dat;
            logic              s1_vld;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_dat <= '0;
                    s1_vld <= 1'b0;
                end else begin
                    s1_vld <= init_done & rre;
                    if (init_done & rre) begin
                        s1_dat <= rd_merged;
                    end
                end
            end

            if (READ_LATENCY == 1) begin : g_lat1
                assign dout       = s1_dat;
                assign dout_valid = s1_vld;
            end else begin : g_lat2
                logic [DATA_W-1:0] s2_dat;
                logic              s2_vld;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        s2_dat <= '0;
                        s2_vld <= 1'b0;
                    end else begin
                        s2_vld <= s1_vld;
                        if (s1_vld) begin
                            s2_dat <= s1_dat;
                        end
                    end
                end

                assign dout       = s2_dat;
                assign dout_valid = s2_vld;
            end
        end
    endgenerate

endmodule

// File: tb/tb_sdp_ram_param.sv
// Directed bench for sdp_ram_param: five instances (latency 0/1/2, both RDW policies,
// DEPTH 16 and 12) share one write/read stimulus stream; expectations are hand-computed.
module tb_sdp_ram_param;
    logic        clk;
    logic        rst_n;
    logic        rst_n_d;
    logic        wre;
    logic [3:0]  wad;
    logic [31:0] di;
    logic [3:0]  wbe;
    logic        rre;
    logic [3:0]  rad;

    logic [31:0] dout_a, dout_b, dout_c, dout_d, dout_e;
    logic        dout_valid_a, dout_valid_b, dout_valid_c, dout_valid_d, dout_valid_e;
    logic        init_done_a, init_done_b, init_done_c, init_done_d, init_done_e;

    int   checks;
    int   errors;
    int   n;
    logic seen_vld;

    sdp_ram_param #(.DATA_W(32), .DEPTH(16), .READ_LATENCY(1), .RDW_NEW(1'b1), .CLEAR_ON_RESET(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .wre(wre), .wad(wad), .di(di), .wbe(wbe), .rre(rre), .rad(rad),
        .dout(dout_a), .dout_valid(dout_valid_a), .init_done(init_done_a));

    sdp_ram_param #(.DATA_W(32), .DEPTH(16), .READ_LATENCY(1), .RDW_NEW(1'b0), .CLEAR_ON_RESET(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .wre(wre), .wad(wad), .di(di), .wbe(wbe), .rre(rre), .rad(rad),
        .dout(dout_b), .dout_valid(dout_valid_b), .init_done(init_done_b));

    sdp_ram_param #(.DATA_W(32), .DEPTH(16), .READ_LATENCY(2), .RDW_NEW(1'b1), .CLEAR_ON_RESET(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .wre(wre), .wad(wad), .di(di), .wbe(wbe), .rre(rre), .rad(rad),
        .dout(dout_c), .dout_valid(dout_valid_c), .init_done(init_done_c));

    sdp_ram_param #(.DATA_W(32), .DEPTH(12), .READ_LATENCY(1), .RDW_NEW(1'b1), .CLEAR_ON_RESET(1'b1)) u_d (
        .clk(clk), .rst_n(rst_n_d), .wre(wre), .wad(wad), .di(di), .wbe(wbe), .rre(rre), .rad(rad),
        .dout(dout_d), .dout_valid(dout_valid_d), .init_done(init_done_d));

    sdp_ram_param #(.DATA_W(32), .DEPTH(16), .READ_LATENCY(0), .RDW_NEW(1'b1), .CLEAR_ON_RESET(1'b0)) u_e (
        .clk(clk), .rst_n(rst_n), .wre(wre), .wad(wad), .di(di), .wbe(wbe), .rre(rre), .rad(rad),
        .dout(dout_e), .dout_valid(dout_valid_e), .init_done(init_done_e));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] l2_exp [4];
        l2_exp[0] = 32'd10;
        l2_exp[1] = 32'd20;
        l2_exp[2] = 32'd30;
        l2_exp[3] = 32'd40;
        checks   = 0;
        errors   = 0;
        seen_vld = 1'b0;
        rst_n    = 1'b0;
        rst_n_d  = 1'b0;
        wre      = 1'b0;
        wad      = 4'd0;
        di       = 32'd0;
        wbe      = 4'h0;
        rre      = 1'b0;
        rad      = 4'd0;

        // Reset values
        repeat (3) step();
        chk("rst_dout", dout_a, 32'd0);
        chk1("rst_vld", dout_valid_a, 1'b0);
        chk1("rst_init", init_done_a, 1'b0);
        chk1("rst_vld_lat2", dout_valid_c, 1'b0);
        chk1("rst_init_noclr", init_done_e, 1'b1);

        // First clear takes exactly 16 cycles
        rst_n = 1'b1;
        n = 0;
        while (init_done_a !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("clear1_cycles", n, 16);

        // Preload every word with a non-zero pattern
        for (int i = 0; i < 16; i++) begin
            wre = 1'b1; wad = 4'(i); di = 32'hDEADBEEF; wbe = 4'hF;
            step();
        end
        wre = 1'b0;
        rre = 1'b1; rad = 4'd9;
        step();
        rre = 1'b0;
        chk("preload", dout_a, 32'hDEADBEEF);

        // Reset again; writes and reads during the clear must be ignored
        rst_n = 1'b0;
        step();
        step();
        chk1("rst2_init", init_done_a, 1'b0);
        wre = 1'b1; wad = 4'd2; di = 32'h00000055; wbe = 4'hF;
        rre = 1'b1; rad = 4'd2;
        rst_n = 1'b1;
        n = 0;
        while (init_done_a !== 1'b1 && n < 100) begin
            step();
            n++;
            if (dout_valid_a === 1'b1) seen_vld = 1'b1;
            if (n == 15) begin
                wre = 1'b0;
                rre = 1'b0;
            end
        end
        chk("clear2_cycles", n, 16);
        chk1("clear_no_vld", seen_vld, 1'b0);

        rre = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rad = 4'(i);
            step();
            chk($sformatf("clr_rd%0d", i), dout_a, 32'd0);
        end
        chk1("clr_rd_vld", dout_valid_a, 1'b1);
        rre = 1'b0;

        // Latency 1 write/read, hold after rre drops
        wre = 1'b1; wad = 4'd5; di = 32'h11223344; wbe = 4'hF;
        step();
        wre = 1'b0;
        rre = 1'b1; rad = 4'd5;
        step();
        chk("l1_data", dout_a, 32'h11223344);
        chk1("l1_vld", dout_valid_a, 1'b1);
        chk1("l2_not_yet", dout_valid_c, 1'b0);
        rre = 1'b0;
        step();
        chk("l1_hold", dout_a, 32'h11223344);
        chk1("l1_vld_drop", dout_valid_a, 1'b0);
        chk("l2_single", dout_c, 32'h11223344);
        chk1("l2_single_vld", dout_valid_c, 1'b1);

        // Byte enables
        wre = 1'b1; wad = 4'd3; di = 32'hAABBCCDD; wbe = 4'hF;
        step();
        di = 32'h11223344; wbe = 4'b0101;
        step();
        wre = 1'b0; wbe = 4'hF;
        rre = 1'b1; rad = 4'd3;
        step();
        rre = 1'b0;
        chk("be_merge", dout_a, 32'hAA22CC44);

        // Read-during-write, same address
        wre = 1'b1; wad = 4'd7; di = 32'hCAFEF00D; wbe = 4'hF;
        rre = 1'b1; rad = 4'd7;
        step();
        wre = 1'b0; rre = 1'b0;
        chk("rdw_new", dout_a, 32'hCAFEF00D);
        chk("rdw_old", dout_b, 32'h00000000);
        step();
        chk("rdw_new_l2", dout_c, 32'hCAFEF00D);
        rre = 1'b1; rad = 4'd7;
        step();
        rre = 1'b0;
        chk("rdw_old_after", dout_b, 32'hCAFEF00D);

        // Latency 2 streaming
        for (int i = 0; i < 4; i++) begin
            wre = 1'b1; wad = 4'(i); di = l2_exp[i]; wbe = 4'hF;
            step();
        end
        wre = 1'b0;
        rre = 1'b1; rad = 4'd0;
        step();
        chk1("l2_first_vld", dout_valid_c, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) rad = 4'(i + 1);
            else rre = 1'b0;
            step();
            chk($sformatf("l2_dat%0d", i), dout_c, l2_exp[i]);
            chk1($sformatf("l2_vld%0d", i), dout_valid_c, 1'b1);
        end
        step();
        chk1("l2_vld_end", dout_valid_c, 1'b0);
        chk("l2_hold", dout_c, 32'd40);

        // Latency 0: combinational read, write visible only after the edge
        rad = 4'd5;
        #1;
        chk("l0_async", dout_e, 32'h11223344);
        chk1("l0_vld", dout_valid_e, 1'b1);
        wre = 1'b1; wad = 4'd9; di = 32'h12345678; wbe = 4'hF; rad = 4'd9;
        #1;
        chk("l0_pre_edge", dout_e, 32'hDEADBEEF);
        step();
        wre = 1'b0;
        chk("l0_post_edge", dout_e, 32'h12345678);

        // DEPTH=12: reset mid-clear at count 5, then full restart
        rst_n_d = 1'b1;
        repeat (5) step();
        chk1("d_mid_init", init_done_d, 1'b0);
        #1 rst_n_d = 1'b0;
        #1;
        chk1("d_rst_vld", dout_valid_d, 1'b0);
        chk1("d_rst_init", init_done_d, 1'b0);
        step();
        rst_n_d = 1'b1;
        n = 0;
        while (init_done_d !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("d_clear_cycles", n, 12);

        // Out-of-range write dropped, out-of-range read returns zero
        wre = 1'b1; wad = 4'd13; di = 32'hFFFFFFFF; wbe = 4'hF;
        step();
        wre = 1'b0;
        rre = 1'b1; rad = 4'd13;
        step();
        rre = 1'b0;
        chk("d_oor_rd", dout_d, 32'd0);
        chk1("d_oor_vld", dout_valid_d, 1'b1);
        chk("a_addr13", dout_a, 32'hFFFFFFFF);
        rre = 1'b1; rad = 4'd1;
        step();
        rre = 1'b0;
        chk("d_no_alias", dout_d, 32'd0);
        wre = 1'b1; wad = 4'd11; di = 32'h0BADCAFE; wbe = 4'hF;
        step();
        wre = 1'b0;
        rre = 1'b1; rad = 4'd11;
        step();
        rre = 1'b0;
        chk("d_last_addr", dout_d, 32'h0BADCAFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
